// File: rtl/udiv_share_pkg.sv
// Shared types and constants for the two-requester divider front end.
package udiv_share_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam int NUM_REQ = 2;
   localparam logic [31:0] QUOT_ALL_ONES = 32'hFFFF_FFFF;

   typedef struct packed {
      logic [31:0] dividend;
      logic [31:0] divisor;
   } req_t;

endpackage

// File: rtl/UDivider.sv
// Combinational restoring array divider; a zero divisor yields all-ones / dividend.
module UDivider #(
   parameter int W = 32
) (
   input  logic [W-1:0] Dividend,
   input  logic [W-1:0] Divisor,
   output logic [W-1:0] Quotient,
   output logic [W-1:0] Remainder
);

   logic [W:0] rem;

   always_comb begin
      rem      = '0;
      Quotient = '0;
      for (int i = W - 1; i >= 0; i--) begin
         rem = {rem[W-1:0], Dividend[i]};
         if (rem >= {1'b0, Divisor}) begin
            rem         = rem - {1'b0, Divisor};
            Quotient[i] = 1'b1;
         end
      end
      Remainder = rem[W-1:0];
   end

endmodule

// File: rtl/udiv_rr_arb.sv
// Two-way round-robin grant: a lone request always wins, ties go to ptr.
module udiv_rr_arb
   import udiv_share_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               ptr,
   output logic [NUM_REQ-1:0] gnt
);

   always_comb begin
      gnt = req;
      if (&req) gnt = ptr ? 2'b10 : 2'b01;
   end

endmodule

// File: rtl/udiv_share_ctrl.sv
// Shares one UDivider between two requesters with a multicycle settle window.
// Build option: UDIV_DIVZERO_TRAP_EN short-circuits zero divisors and raises rsp_err.
module udiv_share_ctrl
   import udiv_share_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int W       = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_valid,
   output logic [NUM_REQ-1:0] req_ready,
   input  logic [W-1:0]       req_dividend0,
   input  logic [W-1:0]       req_divisor0,
   input  logic [W-1:0]       req_dividend1,
   input  logic [W-1:0]       req_divisor1,
   output logic [NUM_REQ-1:0] rsp_valid,
   input  logic [NUM_REQ-1:0] rsp_ready,
   output logic [W-1:0]       rsp_quotient,
   output logic [W-1:0]       rsp_remainder,
   output logic               rsp_err,
   output logic               busy
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t             state, state_nxt;
   logic               rr_ptr;
   logic               tag_q;
   logic [3:0]         cnt;
   req_t               op_q;
   req_t               req_sel;
   logic [W-1:0]       quot_q, rem_q;
   logic [W-1:0]       div_quot, div_rem;
   logic [NUM_REQ-1:0] gnt;
   logic               accept;
   logic               zero_div;

   udiv_rr_arb u_arb (
      .req (req_valid),
      .ptr (rr_ptr),
      .gnt (gnt)
   );

   // Divider sees only the latched operands, so its inputs are frozen through WAIT.
   UDivider #(.W(W)) u_div (
      .Dividend  (op_q.dividend),
      .Divisor   (op_q.divisor),
      .Quotient  (div_quot),
      .Remainder (div_rem)
   );

   always_comb begin
      req_sel.dividend = gnt[1] ? req_dividend1 : req_dividend0;
      req_sel.divisor  = gnt[1] ? req_divisor1  : req_divisor0;
   end

   assign accept = (state == IDLE) && (|gnt);

`ifdef UDIV_DIVZERO_TRAP_EN
   logic err_q;
   assign zero_div = accept && (req_sel.divisor == '0);
   assign rsp_err  = err_q && (state == RESP);
`else
   assign zero_div = 1'b0;
   assign rsp_err  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      req_ready = '0;
      rsp_valid = '0;
      busy      = (state != IDLE);
      case (state)
         IDLE: begin
            req_ready = gnt;
            if (accept) state_nxt = zero_div ? RESP : WAIT;
         end
         WAIT: begin
            if (cnt == '0) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid[tag_q] = 1'b1;
            if (rsp_ready[tag_q]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 1'b0;
         tag_q  <= 1'b0;
         cnt    <= '0;
         op_q   <= '0;
         quot_q <= '0;
         rem_q  <= '0;
`ifdef UDIV_DIVZERO_TRAP_EN
         err_q  <= 1'b0;
`endif
      end else begin
         if (accept) begin
            op_q  <= req_sel;
            tag_q <= gnt[1];
            cnt   <= CNT_INIT;
`ifdef UDIV_DIVZERO_TRAP_EN
            err_q <= zero_div;
            if (zero_div) begin
               quot_q <= QUOT_ALL_ONES;
               rem_q  <= req_sel.dividend;
            end
`endif
         end else if (state == WAIT) begin
            if (cnt == '0) begin
               quot_q <= div_quot;
               rem_q  <= div_rem;
            end else begin
               cnt <= cnt - 4'd1;
            end
         end
         // Hand the next tie to the requester that was not just served.
         if ((state == RESP) && rsp_ready[tag_q]) rr_ptr <= ~tag_q;
      end
   end

   assign rsp_quotient  = quot_q;
   assign rsp_remainder = rem_q;

endmodule

// File: tb/tb_udiv_share_ctrl.sv
// Directed scoreboard bench for udiv_share_ctrl (honours UDIV_DIVZERO_TRAP_EN).
module tb_udiv_share_ctrl;

   localparam int LAT = 4;
`ifdef UDIV_DIVZERO_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [31:0] d0, v0, d1, v1, quo, rem;
   logic        err, busy;

   typedef struct {
      int          tag;
      logic [31:0] q;
      logic [31:0] r;
      logic        e;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   udiv_share_ctrl #(.LATENCY(LAT), .W(32)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_dividend0 (d0),
      .req_divisor0  (v0),
      .req_dividend1 (d1),
      .req_divisor1  (v1),
      .rsp_valid     (rsp_valid),
      .rsp_ready     (rsp_ready),
      .rsp_quotient  (quo),
      .rsp_remainder (rem),
      .rsp_err       (err),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog");
   end

   function automatic exp_t model(input int tag, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      e.tag = tag;
      if (b == 0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
         e.e = TRAP;
      end else begin
         e.q = a / b;
         e.r = a % b;
         e.e = 1'b0;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic check_rsp();
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_empty", 64'd1, 64'd0);
         return;
      end
      e = sb.pop_front();
      check("rsp_valid", 64'(rsp_valid), (e.tag == 1) ? 64'd2 : 64'd1);
      check("quotient", 64'(quo), 64'(e.q));
      check("remainder", 64'(rem), 64'(e.r));
      check("rsp_err", 64'(err), 64'(e.e));
   endtask

   task automatic drive(input int rq, input logic [31:0] a, input logic [31:0] b);
      if (rq == 0) begin d0 = a; v0 = b; end
      else         begin d1 = a; v1 = b; end
      req_valid[rq] = 1'b1;
   endtask

   // Returns just after the accept edge.
   task automatic wait_accept(input int rq);
      int i = 0;
      #1;
      while (!req_ready[rq] && i < 30) begin
         @(posedge clk); #2;
         i++;
      end
      if (!req_ready[rq]) check("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #2;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (rsp_valid == 2'b00 && lat < 40) begin
         @(posedge clk); #2;
         lat++;
      end
   endtask

   task automatic single_op(input int rq, input logic [31:0] a, input logic [31:0] b);
      int lat;
      drive(rq, a, b);
      sb.push_back(model(rq, a, b));
      wait_accept(rq);
      req_valid[rq] = 1'b0;
      wait_rsp(lat);
      check("latency", 64'(lat), (b == 0 && TRAP) ? 64'd1 : 64'(LAT + 1));
      check_rsp();
      @(posedge clk); #2;
      check("busy_after", 64'(busy), 64'd0);
   endtask

   task automatic service(input int n);
      int lat;
      for (int k = 0; k < n; k++) begin
         wait_rsp(lat);
         check_rsp();
         if (k == n - 1) req_valid = 2'b00;
         @(posedge clk); #2;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
   endtask

   initial begin
      exp_t pk;
      int   lat;
      rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b11;
      d0 = '0; v0 = '0; d1 = '0; v1 = '0;
      repeat (2) @(posedge clk);
      #2;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_quo", 64'(quo), 64'd0);
      check("rst_rem", 64'(rem), 64'd0);
      rst_n = 1'b1;
      @(posedge clk); #2;

      // single op and boundary operands
      single_op(0, 32'd100, 32'd7);
      single_op(1, 32'd0, 32'd5);
      single_op(0, 32'd7, 32'd9);
      single_op(1, 32'hFFFF_FFFF, 32'd1);
      single_op(0, 32'h8000_0000, 32'hFFFF_FFFF);
      single_op(0, 32'd1234, 32'd0);

      // contention straight out of reset
      do_reset();
      drive(0, 32'hFFFF_FFFF, 32'd16);
      drive(1, 32'd1000, 32'd33);
      sb.push_back(model(0, 32'hFFFF_FFFF, 32'd16));
      sb.push_back(model(1, 32'd1000, 32'd33));
      service(2);

      // fairness under sustained contention
      drive(0, 32'd77, 32'd5);
      drive(1, 32'd900, 32'd11);
      for (int k = 0; k < 4; k++)
         sb.push_back((k % 2 == 0) ? model(0, 32'd77, 32'd5) : model(1, 32'd900, 32'd11));
      service(4);

      // backpressure on requester 0 while requester 1 waits
      rsp_ready = 2'b10;
      drive(0, 32'd5000, 32'd3);
      sb.push_back(model(0, 32'd5000, 32'd3));
      wait_accept(0);
      req_valid[0] = 1'b0;
      drive(1, 32'd50, 32'd6);
      wait_rsp(lat);
      pk = sb[0];
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 64'(rsp_valid), 64'd1);
         check("bp_quo", 64'(quo), 64'(pk.q));
         check("bp_rem", 64'(rem), 64'(pk.r));
         check("bp_req_ready", 64'(req_ready), 64'd0);
         @(posedge clk); #2;
      end
      check_rsp();
      sb.push_back(model(1, 32'd50, 32'd6));
      rsp_ready = 2'b11;
      @(posedge clk); #2;
      wait_accept(1);
      req_valid[1] = 1'b0;
      wait_rsp(lat);
      check_rsp();
      @(posedge clk); #2;

      // reset in the middle of WAIT
      drive(0, 32'd999, 32'd4);
      wait_accept(0);
      req_valid[0] = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 64'(rsp_valid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_quo", 64'(quo), 64'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #2;
         check("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
      end
      drive(0, 32'd10, 32'd3);
      drive(1, 32'd20, 32'd3);
      sb.push_back(model(0, 32'd10, 32'd3));
      sb.push_back(model(1, 32'd20, 32'd3));
      service(2);
      check("sb_drained", 64'(sb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
